// File: rtl/readout.sv
// Drains the acquisition sample RAM in ascending address order and streams each byte
// to the host transmitter over a valid/ready handshake, one RAM read per byte.
module readout #(
    parameter int unsigned RAM_SIZE   = 1024,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  grant_rd,
    output logic                  done_rd,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_en,
    input  logic [7:0]            rd_data,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        LATCH,
        SEND,
        DONE,
        HOLD
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            tx_data_q;
    logic                  tx_valid_q;
    logic                  done_q;

    // The read strobe is withheld in ISSUE when the grant has already been withdrawn.
    assign rd_en    = (state_q == ISSUE) && grant_rd;
    assign rd_addr  = addr_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign done_rd  = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    addr_q <= '0;
                    if (grant_rd) state_q <= ISSUE;
                end
                ISSUE: begin
                    state_q <= grant_rd ? LATCH : IDLE;
                end
                LATCH: begin
                    if (grant_rd) begin
                        tx_data_q  <= rd_data;
                        tx_valid_q <= 1'b1;
                        state_q    <= SEND;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SEND: begin
                    // A pending byte always completes, even if the grant drops meanwhile.
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        if (addr_q == LAST_ADDR) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (!grant_rd) begin
                            state_q <= IDLE;
                        end else begin
                            addr_q  <= addr_q + ADDR_WIDTH'(1);
                            state_q <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (!grant_rd) state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
